chunked_addsub: RTL and testbench

- Parametrised multi-cycle adder/subtractor for the nibble processor datapath.
- Successor to the fixed 8-bit combinational full adder. Generalised to WIDTH bits.
- Processes CHUNK bits per clock with a registered carry, so wide operands reuse one narrow adder.
- Adds subtraction, a start/busy/done handshake, and a zero flag.

---
 rtl/chunked_addsub_pkg.sv | 7 +
 rtl/full_adder_chunk.sv | 12 +
 rtl/chunked_addsub.sv | 76 +++++++
 tb/tb_chunked_addsub.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/chunked_addsub_pkg.sv
// chunked_addsub_pkg: FSM state encoding and index-counter width helper for chunked_addsub
package chunked_addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/full_adder_chunk.sv
// full_adder_chunk: combinational W-bit adder; in a, b, cin; out soma, cout
module full_adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] soma,
  output logic         cout
);
  assign {cout, soma} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle CHUNK-per-clock add/sub; in clk rst start sub a b cin; out busy done soma cout ovf zero
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] soma,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = idx_w(NCHUNK);
  state_t state;
  logic [WIDTH-1:0] opa, opb, work, fsum;
  logic [IW-1:0] idx;
  logic carry, cc, last;
  logic [CHUNK-1:0] cs;
  full_adder_chunk #(.W(CHUNK)) u_add (
    .a(opa[idx*CHUNK +: CHUNK]),
    .b(opb[idx*CHUNK +: CHUNK]),
    .cin(carry),
    .soma(cs),
    .cout(cc)
  );
  assign last = idx == IW'(NCHUNK - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  // full sum as it will stand once the current chunk is written back
  always_comb begin
    fsum = work;
    fsum[idx*CHUNK +: CHUNK] = cs;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      work  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      soma  <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (state != RUN) begin
      state <= start ? RUN : IDLE;
      if (start) begin
        opa   <= a;
        opb   <= sub ? ~b : b;
        carry <= sub | cin;
        idx   <= '0;
      end
    end else begin
      work[idx*CHUNK +: CHUNK] <= cs;
      carry <= cc;
      idx   <= idx + 1'b1;
      if (last) begin
        state <= DONE;
        soma  <= fsum;
        cout  <= cc;
        ovf   <= (opa[WIDTH-1] == opb[WIDTH-1]) && (fsum[WIDTH-1] != opa[WIDTH-1]);
        zero  <= fsum == '0;
      end
    end
endmodule

// File: tb/tb_chunked_addsub.sv
// tb_chunked_addsub: directed self-checking bench for chunked_addsub (16/4 and 8/8 instances)
module tb_chunked_addsub;
  logic clk = 1'b0, rst = 1'b1, sub = 1'b0, cin = 1'b0;
  logic start16 = 1'b0, start8 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, soma16;
  logic [7:0] a8 = '0, b8 = '0, soma8;
  logic busy16, done16, cout16, ovf16, zero16;
  logic busy8, done8, cout8, ovf8, zero8;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub), .a(a16), .b(b16), .cin(cin),
    .busy(busy16), .done(done16), .soma(soma16), .cout(cout16), .ovf(ovf16), .zero(zero16)
  );
  chunked_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub), .a(a8), .b(b8), .cin(cin),
    .busy(busy8), .done(done8), .soma(soma8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  // issue one operation and observe 8 cycles after the accepting edge; c=1 is the cycle after edge 0
  task automatic do_op(input bit w8, input logic s, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, output int bc, output int dc, output int dn);
    @(negedge clk);
    sub = s;
    cin = ci;
    if (w8) begin start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; end
    else begin start16 = 1'b1; a16 = av; b16 = bv; end
    @(posedge clk);
    #1 start8 = 1'b0;
    start16 = 1'b0;
    bc = 0;
    dc = -1;
    dn = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (w8 ? busy8 : busy16) bc++;
      if (w8 ? done8 : done16) begin
        dn++;
        if (dc < 0) dc = c;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({busy16, done16, soma16, cout16, ovf16, zero16} !== 21'd0) $display("FAIL reset16: got busy=%b done=%b soma=%h cout=%b ovf=%b zero=%b want all 0", busy16, done16, soma16, cout16, ovf16, zero16); else pass++;
    total++; if ({busy8, done8, soma8, cout8, ovf8, zero8} !== 13'd0) $display("FAIL reset8: got busy=%b done=%b soma=%h cout=%b ovf=%b zero=%b want all 0", busy8, done8, soma8, cout8, ovf8, zero8); else pass++;
    rst = 1'b0;
  endtask

  task automatic test_add;
    int bc, dc, dn;
    do_op(1'b0, 1'b0, 16'h9101, 16'h4202, 1'b0, bc, dc, dn);
    total++; if (bc !== 4) $display("FAIL add_busy_cycles: got %0d want 4", bc); else pass++;
    total++; if (dc !== 5 || dn !== 1) $display("FAIL add_done_pulse: got cycle %0d count %0d want cycle 5 count 1", dc, dn); else pass++;
    total++; if ({soma16, cout16, ovf16, zero16} !== {16'hD303, 3'b000}) $display("FAIL add_basic: got soma=%h cout=%b ovf=%b zero=%b want D303 0 0 0", soma16, cout16, ovf16, zero16); else pass++;
  endtask

  task automatic test_carry_ovf;
    int bc, dc, dn;
    do_op(1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, bc, dc, dn);
    total++; if ({soma16, cout16, ovf16, zero16} !== {16'h0000, 3'b101}) $display("FAIL add_wrap: got soma=%h cout=%b ovf=%b zero=%b want 0000 1 0 1", soma16, cout16, ovf16, zero16); else pass++;
    do_op(1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, bc, dc, dn);
    total++; if ({soma16, cout16, ovf16, zero16} !== {16'h8000, 3'b010}) $display("FAIL add_ovf: got soma=%h cout=%b ovf=%b zero=%b want 8000 0 1 0", soma16, cout16, ovf16, zero16); else pass++;
    do_op(1'b0, 1'b0, 16'h00F0, 16'h000F, 1'b1, bc, dc, dn);
    total++; if ({soma16, cout16, ovf16, zero16} !== {16'h0100, 3'b000}) $display("FAIL add_cin: got soma=%h cout=%b ovf=%b zero=%b want 0100 0 0 0", soma16, cout16, ovf16, zero16); else pass++;
  endtask

  task automatic test_sub;
    int bc, dc, dn;
    do_op(1'b0, 1'b1, 16'h0005, 16'h0007, 1'b1, bc, dc, dn);
    total++; if ({soma16, cout16, ovf16, zero16} !== {16'hFFFE, 3'b000}) $display("FAIL sub_neg: got soma=%h cout=%b ovf=%b zero=%b want FFFE 0 0 0", soma16, cout16, ovf16, zero16); else pass++;
    total++; if (bc !== 4 || dc !== 5) $display("FAIL sub_timing: got busy %0d done cycle %0d want 4 5", bc, dc); else pass++;
    do_op(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b0, bc, dc, dn);
    total++; if ({soma16, cout16, ovf16, zero16} !== {16'h7FFF, 3'b110}) $display("FAIL sub_ovf: got soma=%h cout=%b ovf=%b zero=%b want 7FFF 1 1 0", soma16, cout16, ovf16, zero16); else pass++;
  endtask

  task automatic test_ignore_start;
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; start16 = 1'b1; a16 = 16'h0005; b16 = 16'h0003;
    @(posedge clk);
    #1 start16 = 1'b0;
    @(negedge clk);
    total++; if (soma16 !== 16'h7FFF) $display("FAIL hold_during_run: got soma=%h want 7FFF", soma16); else pass++;
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h1111; b16 = 16'h1111;
    @(posedge clk);
    #1 start16 = 1'b0;
    a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    total++; if (done16 !== 1'b1 || soma16 !== 16'h0008) $display("FAIL ignore_start: got done=%b soma=%h want 1 0008", done16, soma16); else pass++;
    @(negedge clk);
    total++; if (done16 !== 1'b0 || busy16 !== 1'b0) $display("FAIL ignore_no_new_op: got done=%b busy=%b want 0 0", done16, busy16); else pass++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; start16 = 1'b1; a16 = 16'h0001; b16 = 16'h0002;
    @(posedge clk);
    #1 start16 = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (done16 !== 1'b1 || soma16 !== 16'h0003) $display("FAIL b2b_first: got done=%b soma=%h want 1 0003", done16, soma16); else pass++;
    start16 = 1'b1; a16 = 16'h0010; b16 = 16'h0020;
    @(posedge clk);
    #1 start16 = 1'b0;
    @(negedge clk);
    total++; if (busy16 !== 1'b1 || done16 !== 1'b0 || soma16 !== 16'h0003) $display("FAIL b2b_no_gap: got busy=%b done=%b soma=%h want 1 0 0003", busy16, done16, soma16); else pass++;
    repeat (3) @(negedge clk);
    @(negedge clk);
    total++; if (done16 !== 1'b1 || soma16 !== 16'h0030) $display("FAIL b2b_second: got done=%b soma=%h want 1 0030", done16, soma16); else pass++;
  endtask

  task automatic test_reset_mid_run;
    int dn;
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; start16 = 1'b1; a16 = 16'h8888; b16 = 16'h8888;
    @(posedge clk);
    #1 start16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if ({busy16, done16, soma16, cout16, ovf16, zero16} !== 21'd0) $display("FAIL mid_reset: got busy=%b done=%b soma=%h cout=%b ovf=%b zero=%b want all 0", busy16, done16, soma16, cout16, ovf16, zero16); else pass++;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done16) dn++;
    end
    total++; if (dn !== 0) $display("FAIL mid_reset_no_done: got %0d done cycles want 0", dn); else pass++;
  endtask

  task automatic test_single_chunk;
    int bc, dc, dn;
    do_op(1'b1, 1'b0, 16'h00FE, 16'h0001, 1'b1, bc, dc, dn);
    total++; if ({soma8, cout8, ovf8, zero8} !== {8'h00, 3'b101}) $display("FAIL w8_add: got soma=%h cout=%b ovf=%b zero=%b want 00 1 0 1", soma8, cout8, ovf8, zero8); else pass++;
    total++; if (bc !== 1 || dc !== 2 || dn !== 1) $display("FAIL w8_timing: got busy %0d done cycle %0d count %0d want 1 2 1", bc, dc, dn); else pass++;
  endtask

  initial begin
    test_reset;
    test_add;
    test_carry_ovf;
    test_sub;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_single_chunk;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
